spi_coef_loader: RTL and testbench

//  SPI-slave packet receiver directly upstream of the FIR datapath in filter_top.

---
 rtl/filter_pkg.sv | 30 +++
 rtl/spi_coef_loader_rx.sv | 78 +++++++
 rtl/spi_coef_loader.sv | 106 ++++++++++
 tb/tb_spi_coef_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared types and constants for the SPI coefficient loader.
// Frame layout struct, command bytes and the receiver state enum.
package filter_pkg;

    localparam int WORD_W = 32;
    localparam int N_TAPS = 32;
    localparam int ADDR_W = 5;
    localparam int COEF_W = 12;
    localparam int CNT_W  = 5;

    localparam logic [7:0] CMD_WR  = 8'hFB;
    localparam logic [7:0] CMD_CLR = 8'hFC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_COMMIT,
        ST_WAIT
    } spi_st_e;

    typedef struct packed {
        logic [7:0]        cmd;
        logic [2:0]        rsvd_hi;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        rsvd_lo;
        logic [COEF_W-1:0] coef;
    } coef_pkt_t;

endpackage

// File: rtl/spi_coef_loader_rx.sv
// SPI frame receiver: setup slot, 32-bit MSB-first shift, abort on CS high.
// Ports: clk_i, rst_ni, cs_i, mosi_i in; st_o, bitcnt_o, word_vld_o, word_o out.
module spi_coef_loader_rx
    import filter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cs_i,
    input  logic              mosi_i,
    output spi_st_e           st_o,
    output logic [CNT_W-1:0]  bitcnt_o,
    output logic              word_vld_o,
    output logic [WORD_W-1:0] word_o
);

    spi_st_e           st_q, st_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q     <= ST_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
        end else begin
            st_q     <= st_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        unique case (st_q)
            ST_IDLE: begin
                if (!cs_i) begin
                    st_d     = ST_SETUP;
                    bitcnt_d = '0;
                end
            end
            ST_SETUP: begin
                st_d = cs_i ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cs_i) begin
                    // Abort: partial word never reaches COMMIT
                    st_d     = ST_IDLE;
                    bitcnt_d = '0;
                end else begin
                    shreg_d  = {shreg_q[WORD_W-2:0], mosi_i};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == CNT_W'(WORD_W - 1)) begin
                        st_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                st_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cs_i) begin
                    st_d = ST_IDLE;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    assign st_o       = st_q;
    assign bitcnt_o   = bitcnt_q;
    assign word_vld_o = (st_q == ST_COMMIT);
    assign word_o     = shreg_q;

endmodule

// File: rtl/spi_coef_loader.sv
// SPI-slave coefficient loader: decodes frames into FIR tap writes.
// Ports: Clk, Hlt_n, CS, MOSI in; MISO, coef_we/addr/data, coef_ready, err_cnt out.
module spi_coef_loader
    import filter_pkg::*;
(
    input  logic              Clk,
    input  logic              Hlt_n,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              coef_we,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [COEF_W-1:0] coef_data,
    output logic              coef_ready,
    output logic [7:0]        err_cnt
);

    spi_st_e           st;
    logic [CNT_W-1:0]  bitcnt;
    logic              word_vld;
    logic [WORD_W-1:0] word;
    coef_pkt_t         pkt;

    logic              is_wr, is_clr, is_bad;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COEF_W-1:0] data_q, data_d;
    logic [N_TAPS-1:0] mask_q, mask_d;
    logic              ready_q, ready_d;
    logic [7:0]        err_q, err_d;
    logic [WORD_W-1:0] rb_q, rb_d;

    spi_coef_loader_rx u_rx (
        .clk_i      (Clk),
        .rst_ni     (Hlt_n),
        .cs_i       (CS),
        .mosi_i     (MOSI),
        .st_o       (st),
        .bitcnt_o   (bitcnt),
        .word_vld_o (word_vld),
        .word_o     (word)
    );

    assign pkt = coef_pkt_t'(word);

    // Out-of-range tap index falls through to the error path
    assign is_wr  = word_vld && (pkt.cmd == CMD_WR)
                    && (int'(pkt.addr) < N_TAPS);
    assign is_clr = word_vld && (pkt.cmd == CMD_CLR);
    assign is_bad = word_vld && !is_wr && !is_clr;

    always_comb begin
        we_d    = is_wr;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        err_d   = err_q;
        rb_d    = rb_q;
        ready_d = &mask_q;
        if (is_wr) begin
            addr_d         = pkt.addr;
            data_d         = pkt.coef;
            mask_d[pkt.addr] = 1'b1;
        end
        if (is_clr) begin
            mask_d = '0;
        end
        if (is_bad && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
        if (word_vld) begin
            rb_d = pkt;
        end
    end

    always_ff @(posedge Clk or negedge Hlt_n) begin
        if (!Hlt_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= '0;
            rb_q    <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rb_q    <= rb_d;
        end
    end

    // Readback bit follows the bit counter, so it advances on each sample edge
    assign MISO = (st == ST_SHIFT) ? rb_q[CNT_W'(WORD_W - 1) - bitcnt] : 1'b0;

    assign coef_we    = we_q;
    assign coef_addr  = addr_q;
    assign coef_data  = data_q;
    assign coef_ready = ready_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_spi_coef_loader.sv
// Randomised self-checking bench for spi_coef_loader.
// Host-side frame driver plus a behavioural loader model.
module tb_spi_coef_loader;

    logic        Clk = 1'b0;
    logic        Hlt_n = 1'b0;
    logic        CS = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [11:0] coef_data;
    logic        coef_ready;
    logic [7:0]  err_cnt;

    int n_chk = 0;
    int n_fail = 0;

    bit [31:0] m_mask;
    int        m_err;
    bit        m_ready;
    bit [4:0]  m_addr;
    bit [11:0] m_data;
    bit [31:0] m_rb;

    spi_coef_loader dut (
        .Clk        (Clk),
        .Hlt_n      (Hlt_n),
        .CS         (CS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .err_cnt    (err_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask  = '0;
        m_err   = 0;
        m_ready = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_rb    = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    coef_we,    0);
        chk({tag, "_addr"},  coef_addr,  0);
        chk({tag, "_data"},  coef_data,  0);
        chk({tag, "_ready"}, coef_ready, 0);
        chk({tag, "_err"},   err_cnt,    0);
        chk({tag, "_miso"},  MISO,       0);
    endtask

    // Negedge i sees the result of rising edge i of the frame:
    // edge 1 enters setup, edges 3..34 sample bits 31..0, edge 35 commits.
    task automatic send(input logic [31:0] w, input int n_low,
                        input int n_high);
        bit       full;
        bit       wr;
        bit       exp_we;
        bit       exp_miso;
        bit [7:0] cmd;
        full = (n_low >= 34);
        cmd  = w[31:24];
        wr   = 1'b0;
        for (int i = 0; i < n_low + n_high; i++) begin
            @(negedge Clk);
            if (i >= 1) begin
                if (full && i == 35) begin
                    if (cmd == 8'hFB) begin
                        wr = 1'b1;
                        m_addr = w[20:16];
                        m_data = w[11:0];
                        m_mask[w[20:16]] = 1'b1;
                    end else if (cmd == 8'hFC) begin
                        m_mask = '0;
                    end else if (m_err < 255) begin
                        m_err++;
                    end
                    m_rb = w;
                end
                if (full && i == 36) begin
                    m_ready = (m_mask == 32'hFFFF_FFFF);
                end
                exp_we = full && wr && (i == 35);
                exp_miso = 1'b0;
                if (i >= 2 && i <= 33 && i <= n_low) begin
                    exp_miso = m_rb[33 - i];
                end
                chk("we",    coef_we,    exp_we);
                chk("addr",  coef_addr,  m_addr);
                chk("data",  coef_data,  m_data);
                chk("ready", coef_ready, m_ready);
                chk("err",   err_cnt,    m_err);
                chk("miso",  MISO,       exp_miso);
            end
            CS = (i < n_low) ? 1'b0 : 1'b1;
            if (i >= 2 && i <= 33) begin
                MOSI = w[33 - i];
            end else begin
                MOSI = 1'($urandom);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          r;
        int          nl;
        int          nh;

        model_reset();
        repeat (3) @(negedge Clk);
        chk_all_zero("rst");
        Hlt_n = 1'b1;
        repeat (2) @(negedge Clk);
        chk_all_zero("idle");

        for (int i = 0; i < 32; i++) begin
            w = {8'hFB, 3'b0, 5'(i), 4'b0, 12'(i * 3)};
            send(w, 54, 3);
        end
        chk("load_ready", coef_ready, 1);

        send(32'hFC00_0000, 54, 3);
        chk("clr_ready", coef_ready, 0);

        send(32'h1234_0ABC, 54, 3);
        chk("bad_err", err_cnt, 1);
        send(32'hFB1F_0FFF, 54, 3);
        chk("hi_addr", coef_addr, 31);
        chk("hi_data", coef_data, 12'hFFF);

        send(32'hFB05_0123, 22, 3);
        chk("abort_err", err_cnt, 1);
        chk("abort_addr", coef_addr, 31);
        send(32'hFB05_0123, 54, 3);
        chk("after_abort", coef_addr, 5);

        send(32'hFB02_0456, 54, 3);
        send(32'hFC00_0000, 54, 3);

        send(32'hFB0A_0111, 36, 1);
        send(32'hFB0B_0222, 36, 1);
        chk("b2b_data", coef_data, 12'h222);

        send(32'hFB03_0777, 15, 0);
        @(negedge Clk);
        #1 Hlt_n = 1'b0;
        #1 chk_all_zero("async");
        model_reset();
        CS = 1'b1;
        @(negedge Clk);
        Hlt_n = 1'b1;
        repeat (2) @(negedge Clk);
        send(32'hFB07_0ABC, 54, 3);
        chk("post_rst", coef_data, 12'hABC);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            w = $urandom;
            if (r < 45) begin
                w[31:24] = 8'hFB;
            end else if (r < 52) begin
                w[31:24] = 8'hFC;
            end
            if ($urandom_range(0, 99) < 15) begin
                nl = $urandom_range(1, 33);
            end else begin
                nl = $urandom_range(36, 50);
            end
            nh = $urandom_range(1, 3);
            send(w, nl, nh);
        end

        for (int k = 0; k < 260; k++) begin
            send(32'h0000_0000, 36, 1);
        end
        chk("sat_err", err_cnt, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
